led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//   Sequences the board LED bank (40 pattern LEDs + 4 blink LEDs) for the LVDS TX / GPIO blink test.
//   Divides clk into a step tick and runs a mode FSM: off, walking-one, bounce, binary count, all-blink.
//   A valid/ready request port lets a host or test controller switch modes.
//   Each switch takes effect only on a tick boundary, so patterns never glitch mid-step.
//   Sits directly under the test top level; led/blink map straight to the top-level LED pins.
// PARAMETERS
//   TICK_DIV  25_000_000  clk cycles per pattern step (>=2)
//   N_LED     40          width of pattern LED bank (>=2)
//   N_BLINK   4           width of blink status LEDs
// PORTS
//   clk             in   1        system clock, single domain
//   rst             in   1        synchronous, active-high reset
//   mode_req_valid  in   1        mode change request valid
//   mode_req        in   3        requested mode (encoding below)
//   mode_req_ready  out  1        request can be accepted this cycle
//   step_tick       out  1        1-cycle pulse at each pattern step
//   cur_mode        out  3        mode currently displayed
//   led             out  N_LED    pattern LED drive, 1 = on
//   blink           out  N_BLINK  free-running step counter, 1 = on
// BEHAVIOUR
//   Reset (rst=1 at posedge): led=0, blink=0, cur_mode=OFF, step_tick=0, mode_req_ready=1,
//     prescaler=0, nothing pending. Applies mid-pattern and mid-pending; any pending request is dropped.
//   Prescaler: cnt runs 0..TICK_DIV-1 and wraps to 0.
//     step_tick=1 for exactly the cycle in which cnt==TICK_DIV-1, so the tick period is TICK_DIV cycles.
//   Modes: 0=OFF, 1=WALK, 2=BOUNCE, 3=COUNT, 4=ALLBLINK; codes 5-7 are decoded as OFF.
//   Handshake:
//     - Accept when mode_req_valid && mode_req_ready; the request is latched as pending and ready drops to 0.
//     - ready returns to 1 the cycle after the pending mode is applied.
//     - valid while ready=0 is ignored. The requester must hold valid until accepted.
//   Apply: on the first step_tick strictly after the accept cycle:
//     - cur_mode <= pending.
//     - led <= the mode's initial pattern, visible the cycle after that tick.
//   Initial patterns: OFF=0; WALK=bit0; BOUNCE=bit0 with direction up; COUNT=0; ALLBLINK=all ones.
//   If accept and tick happen in the same cycle, the apply waits for the next tick.
//   A request for the current mode restarts that mode from its initial pattern.
//   On each step_tick with no apply:
//     - OFF: led stays 0.
//     - WALK: rotate left by 1; bit N_LED-1 wraps to bit0.
//     - BOUNCE: the single lit bit moves toward the current direction.
//       Direction reverses on reaching bit N_LED-1 or bit0; endpoints are lit for one step only
//       (... 38, 39, 38 ...).
//     - COUNT: led <= led+1 mod 2^N_LED; all-ones wraps to 0.
//     - ALLBLINK: led <= ~led.
//   blink increments mod 2^N_BLINK on every step_tick regardless of mode or apply.
//   All outputs are registered, with no combinational path from inputs to outputs.
//     Exception: mode_req_ready is a register, so it has no input dependency either.
// STRUCTURE
//   Package led_seq_pkg: MODE_OFF..MODE_ALLBLINK localparams, MODE_W=3, mode decode function.
//   Sub-module tick_prescaler (#TICK_DIV): clk, rst -> tick. The rest is one FSM in this module:
//     - mode register, pending register + flag;
//     - led/blink datapath;
//     - bounce direction bit.
// TESTING  (bench uses TICK_DIV=4, N_LED=40, N_BLINK=4)
//   1. Release reset, idle 20 cycles -> step_tick every 4th cycle; led=0; blink counts 0,1,2,... per tick;
//      ready=1.
//   2. Request WALK (1) -> ready=0 next cycle; after the next tick led=0x1 and ready=1;
//      after 40 more ticks led=0x1 again (wrap from bit39 to bit0).
//   3. BOUNCE -> lit bit index sequence 0,1..39,38..0,1; bit39 is lit for exactly one tick.
//   4. COUNT for 5 ticks -> led=5. Force led to all-ones via 2^40-1 steps (or a backdoor)
//      -> the next tick gives 0. ALLBLINK -> led alternates FF_FFFF_FFFF / 0 per tick.
//   5. Hold valid with mode 2 while ready=0 -> no second accept; request code 6 -> cur_mode=OFF, led=0.
//   6. Assert rst while a request is pending in WALK mid-rotation -> the next cycle has all outputs at
//      reset values; the pending request is never applied.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared mode encoding and request decode for the LED pattern sequencer.
package led_seq_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF      = 3'd0;
  localparam logic [MODE_W-1:0] MODE_WALK     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BOUNCE   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_COUNT    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ALLBLINK = 3'd4;

  // Unused codes fold onto OFF so the mode register only ever holds legal modes.
  function automatic logic [MODE_W-1:0] decode_mode(input logic [MODE_W-1:0] code);
    return (code > MODE_ALLBLINK) ? MODE_OFF : code;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV cycles; tick is registered.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
  end

  // tick_q tracks "cnt_q == CntMax" one register stage ahead so it lines up exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CntMax);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: mode FSM with tick-aligned mode switching over a valid/ready port.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned N_LED    = 40,
  parameter int unsigned N_BLINK  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_req_valid,
  input  logic [MODE_W-1:0]  mode_req,
  output logic               mode_req_ready,
  output logic               step_tick,
  output logic [MODE_W-1:0]  cur_mode,
  output logic [N_LED-1:0]   led,
  output logic [N_BLINK-1:0] blink
);

  logic               tick;
  logic [MODE_W-1:0]  mode_q, pend_q;
  logic               pend_valid_q, ready_q, dir_q;
  logic [N_LED-1:0]   led_q;
  logic [N_BLINK-1:0] blink_q;

  logic [N_LED-1:0]   led_step, led_init;
  logic               dir_step, move_up;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    led_step = '0;
    dir_step = dir_q;
    move_up  = 1'b0;
    case (mode_q)
      MODE_WALK:     led_step = {led_q[N_LED-2:0], led_q[N_LED-1]};
      MODE_BOUNCE: begin
        // Turn around at either end so endpoints are lit for a single step.
        move_up  = dir_q ? ~led_q[N_LED-1] : led_q[0];
        led_step = move_up ? (led_q << 1) : (led_q >> 1);
        dir_step = move_up;
      end
      MODE_COUNT:    led_step = led_q + N_LED'(1);
      MODE_ALLBLINK: led_step = ~led_q;
      default:       led_step = '0;
    endcase
  end

  always_comb begin
    case (pend_q)
      MODE_WALK, MODE_BOUNCE: led_init = N_LED'(1);
      MODE_ALLBLINK:          led_init = '1;
      default:                led_init = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_OFF;
      pend_q       <= MODE_OFF;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      dir_q        <= 1'b1;
      led_q        <= '0;
      blink_q      <= '0;
    end else begin
      if (tick) begin
        blink_q <= blink_q + N_BLINK'(1);
        if (pend_valid_q) begin
          mode_q       <= pend_q;
          led_q        <= led_init;
          dir_q        <= 1'b1;
          pend_valid_q <= 1'b0;
          ready_q      <= 1'b1;
        end else begin
          led_q <= led_step;
          dir_q <= dir_step;
        end
      end
      // ready_q is low whenever a request is pending, so accept never races an apply.
      if (mode_req_valid && ready_q) begin
        pend_q       <= decode_mode(mode_req);
        pend_valid_q <= 1'b1;
        ready_q      <= 1'b0;
      end
    end
  end

  assign mode_req_ready = ready_q;
  assign step_tick      = tick;
  assign cur_mode       = mode_q;
  assign led            = led_q;
  assign blink          = blink_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus pushes expected post-tick state, monitor pops on each step_tick.
module tb_led_pattern_sequencer;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_req_valid = 1'b0;
  logic [2:0]  mode_req = 3'd0;
  logic        mode_req_ready, step_tick;
  logic [2:0]  cur_mode;
  logic [39:0] led;
  logic [3:0]  blink;

  // Narrow instance so the counter wrap from all-ones is reachable in a few ticks.
  logic        s_valid = 1'b0;
  logic [2:0]  s_req = 3'd0;
  logic        s_ready, s_tick;
  logic [2:0]  s_mode;
  logic [3:0]  s_led;
  logic [1:0]  s_blink;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.TICK_DIV(TD), .N_LED(40), .N_BLINK(4)) dut (
    .clk(clk), .rst(rst), .mode_req_valid(mode_req_valid), .mode_req(mode_req),
    .mode_req_ready(mode_req_ready), .step_tick(step_tick), .cur_mode(cur_mode),
    .led(led), .blink(blink)
  );

  led_pattern_sequencer #(.TICK_DIV(2), .N_LED(4), .N_BLINK(2)) dut_s (
    .clk(clk), .rst(rst), .mode_req_valid(s_valid), .mode_req(s_req),
    .mode_req_ready(s_ready), .step_tick(s_tick), .cur_mode(s_mode),
    .led(s_led), .blink(s_blink)
  );

  typedef struct packed {
    logic [39:0] led;
    logic [3:0]  blink;
    logic [2:0]  mode;
    logic        ready;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   tick_prev = 1'b0;

  logic [39:0] m_led;
  logic [3:0]  m_blink;
  logic [2:0]  m_mode, m_pend;
  bit          m_pend_v, m_ready, m_dir;
  int          m_idx, m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_blink = '0; m_mode = 3'd0; m_pend = 3'd0;
    m_pend_v = 1'b0; m_ready = 1'b1; m_dir = 1'b1; m_idx = 0; m_cnt = 0;
  endtask

  // Called at a negedge with inputs already driven; advances one clock.
  task automatic cycle();
    bit   tk, acc;
    exp_t e;
    tk = (m_cnt == TD - 1);
    chk("step_tick", step_tick, tk);
    chk("ready", mode_req_ready, m_ready);
    if (rst) begin
      model_reset();
    end else begin
      acc = mode_req_valid && m_ready;
      if (tk) begin
        m_blink = m_blink + 4'd1;
        if (m_pend_v) begin
          m_mode = m_pend; m_idx = 0; m_dir = 1'b1; m_pend_v = 1'b0; m_ready = 1'b1;
          m_led = (m_mode == 3'd1 || m_mode == 3'd2) ? 40'd1 :
                  (m_mode == 3'd4) ? {40{1'b1}} : 40'd0;
        end else begin
          case (m_mode)
            3'd1: m_led = (m_led << 1) | (m_led >> 39);
            3'd2: begin
              if (m_dir) begin
                if (m_idx == 39) begin m_idx = 38; m_dir = 1'b0; end else m_idx++;
              end else begin
                if (m_idx == 0) begin m_idx = 1; m_dir = 1'b1; end else m_idx--;
              end
              m_led = 40'd1 << m_idx;
            end
            3'd3: m_led = m_led + 40'd1;
            3'd4: m_led = ~m_led;
            default: m_led = '0;
          endcase
        end
      end
      if (acc) begin
        m_pend = (mode_req > 3'd4) ? 3'd0 : mode_req;
        m_pend_v = 1'b1;
        m_ready = 1'b0;
      end
      m_cnt = tk ? 0 : m_cnt + 1;
    end
    if (tk) begin
      e.led = m_led; e.blink = m_blink; e.mode = m_mode; e.ready = m_ready;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    while (k < n) begin
      if (m_cnt == TD - 1) k++;
      cycle();
    end
  endtask

  task automatic request(input logic [2:0] code);
    bit acc;
    mode_req_valid = 1'b1;
    mode_req = code;
    for (int i = 0; i < 16; i++) begin
      acc = m_ready;
      cycle();
      if (acc) break;
    end
    mode_req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && tick_prev) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: step output at t=%0t, expected none", $time);
      end else begin
        e = sb_q.pop_front();
        chk("sb_led", led, e.led);
        chk("sb_blink", blink, e.blink);
        chk("sb_mode", cur_mode, e.mode);
        chk("sb_ready", mode_req_ready, e.ready);
      end
    end
    tick_prev = mon_en && step_tick;
  end

  initial begin
    int b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    mon_en = 1'b1;
    chk("rst_led", led, 0);
    chk("rst_blink", blink, 0);
    chk("rst_mode", cur_mode, 0);
    chk("rst_tick", step_tick, 0);
    chk("rst_ready", mode_req_ready, 1);
    rst = 1'b0;

    // Idle: ticks every 4th cycle, blink counts.
    run_cycles(20);
    chk("idle_blink", blink, 5);
    chk("idle_led", led, 0);

    // WALK and wrap bit39 -> bit0.
    request(3'd1);
    chk("walk_ready_low", mode_req_ready, 0);
    run_ticks(1);
    chk("walk_init", led, 40'h1);
    chk("walk_ready_back", mode_req_ready, 1);
    chk("walk_mode", cur_mode, 1);
    run_ticks(39);
    chk("walk_bit39", led, 40'h80_0000_0000);
    run_ticks(1);
    chk("walk_wrap", led, 40'h1);

    // BOUNCE endpoints.
    request(3'd2);
    run_ticks(1);
    chk("bounce_init", led, 40'h1);
    run_ticks(39);
    chk("bounce_top", led, 40'h80_0000_0000);
    run_ticks(1);
    chk("bounce_turn", led, 40'h40_0000_0000);
    run_ticks(38);
    chk("bounce_bottom", led, 40'h1);
    run_ticks(1);
    chk("bounce_up", led, 40'h2);

    // COUNT then ALLBLINK.
    request(3'd3);
    run_ticks(1);
    chk("count_init", led, 0);
    run_ticks(5);
    chk("count_5", led, 5);
    request(3'd4);
    run_ticks(1);
    chk("blink_ones", led, 40'hFF_FFFF_FFFF);
    run_ticks(1);
    chk("blink_zero", led, 0);
    run_ticks(1);
    chk("blink_ones2", led, 40'hFF_FFFF_FFFF);

    // Valid held while not ready must not produce a second accept.
    request(3'd3);
    mode_req_valid = 1'b1;
    mode_req = 3'd2;
    while (m_pend_v) cycle();
    mode_req_valid = 1'b0;
    chk("hold_mode", cur_mode, 3);
    chk("hold_ready", mode_req_ready, 1);
    run_ticks(1);
    chk("hold_count", led, 1);
    chk("hold_mode2", cur_mode, 3);

    // Code 6 decodes to OFF.
    request(3'd6);
    run_ticks(1);
    chk("code6_mode", cur_mode, 0);
    chk("code6_led", led, 0);

    // Reset mid-rotation with a request pending.
    request(3'd1);
    run_ticks(4);
    chk("pre_rst_led", led, 40'h8);
    request(3'd2);
    chk("pre_rst_pend", mode_req_ready, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_led", led, 0);
    chk("mid_rst_blink", blink, 0);
    chk("mid_rst_mode", cur_mode, 0);
    chk("mid_rst_tick", step_tick, 0);
    chk("mid_rst_ready", mode_req_ready, 1);
    run_ticks(2);
    chk("drop_mode", cur_mode, 0);
    chk("drop_led", led, 0);

    // Narrow instance: count up through all-ones and wrap to 0.
    chk("s_ready", s_ready, 1);
    s_valid = 1'b1;
    s_req = 3'd3;
    cycle();
    s_valid = 1'b0;
    b = 0;
    while (s_mode !== 3'd3 && b < 16) begin cycle(); b++; end
    chk("s_mode", s_mode, 3);
    chk("s_init", s_led, 0);
    for (int t = 1; t <= 16; t++) begin
      b = 0;
      while (s_tick !== 1'b1 && b < 8) begin cycle(); b++; end
      chk("s_tick_seen", s_tick, 1);
      cycle();
      chk("s_count", s_led, 64'(t % 16));
    end

    while (m_cnt == TD - 1) cycle();
    #1;
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
